alu_result_collector: RTL and testbench



---
 rtl/alu_result_collector.sv | 122 ++++++++++++
 tb/tb_alu_result_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_collector.sv
// Tracks ALU commands through a fixed-latency tag delay line and captures each matured result
// into a first-word-fall-through FIFO with credit and drop accounting.
module alu_result_collector #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_i,
  input  logic [TAG_W-1:0]          issue_tag_i,
  input  logic [2*WIDTH-1:0]        alu_res_i,
  input  logic                      alu_cout_i,
  input  logic                      alu_oflow_i,
  input  logic                      alu_e_i,
  input  logic                      alu_g_i,
  input  logic                      alu_l_i,
  input  logic                      alu_err_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [TAG_W+2*WIDTH+5:0]  out_data_o,
  output logic [$clog2(DEPTH):0]    out_count_o,
  output logic                      credit_ok_o,
  output logic                      drop_err_o,
  output logic [7:0]                drop_cnt_o,
  input  logic                      clr_err_i
);
  localparam int DW = TAG_W + 2*WIDTH + 6;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             drop_err_q, drop_err_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             cap_vld, full, pop, push, drop;
  logic [DW-1:0]    cap_dat;
  logic [IW-1:0]    inflight;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= issue_i;
      tag_q[0] <= issue_tag_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // The last delay stage coincides with the edge at which the ALU outputs are valid.
  assign cap_vld = vld_q[LAT-1];
  assign cap_dat = {tag_q[LAT-1], alu_res_i, alu_cout_i, alu_oflow_i,
                    alu_e_i, alu_g_i, alu_l_i, alu_err_i};

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign push        = cap_vld && (!full || pop);
  assign drop        = cap_vld && full && !pop;

  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    drop_cnt_d = drop_cnt_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear leaves a fresh count of one.
    if (drop) begin
      drop_err_d = 1'b1;
      if (clr_err_i)                drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_err_i) begin
      drop_err_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + IW'(vld_q[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cap_dat;
  end

  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign out_count_o = count_q;
  assign credit_ok_o = (SW'(count_q) + SW'(inflight)) < SW'(DEPTH);
  assign drop_err_o  = drop_err_q;
  assign drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_result_collector;
  localparam int WIDTH = 8, LAT = 2, DEPTH = 4, TAG_W = 4;
  localparam int DW = TAG_W + 2*WIDTH + 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           issue;
  logic [3:0]     issue_tag;
  logic [15:0]    alu_res;
  logic [5:0]     flg;
  logic           out_ready, clr_err;
  logic           out_valid, credit_ok, drop_err;
  logic [DW-1:0]  out_data;
  logic [2:0]     out_count;
  logic [7:0]     drop_cnt;

  alu_result_collector #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_i(issue), .issue_tag_i(issue_tag),
    .alu_res_i(alu_res), .alu_cout_i(flg[5]), .alu_oflow_i(flg[4]), .alu_e_i(flg[3]),
    .alu_g_i(flg[2]), .alu_l_i(flg[1]), .alu_err_i(flg[0]),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_count_o(out_count), .credit_ok_o(credit_ok), .drop_err_o(drop_err),
    .drop_cnt_o(drop_cnt), .clr_err_i(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int e; logic [3:0] tag; } pend_t;
  pend_t         pend[$];
  logic [DW-1:0] mq[$];
  bit            m_derr;
  int            m_dcnt;
  int            n_edge = 0;

  typedef struct {
    logic iss; logic [3:0] tag; logic [15:0] res; logic [5:0] f; logic rdy;
    logic exp_vld; logic [2:0] exp_cnt; logic exp_cr; logic [DW-1:0] exp_dat;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_derr = 0;
    m_dcnt = 0;
  endtask

  // One clock edge of the intended behaviour, using the inputs present at that edge.
  task automatic model_edge();
    bit pop, cap, full;
    logic [3:0] t;
    if (!rst_n) begin
      model_reset();
    end else begin
      pop  = (mq.size() != 0) && out_ready;
      cap  = (pend.size() != 0) && (pend[0].e == n_edge - LAT);
      full = (mq.size() == DEPTH);
      t    = 4'h0;
      if (cap) t = pend.pop_front().tag;
      if (pop) void'(mq.pop_front());
      if (cap && (!full || pop)) begin
        mq.push_back({t, alu_res, flg});
        if (clr_err) begin m_derr = 0; m_dcnt = 0; end
      end else if (cap) begin
        m_derr = 1;
        m_dcnt = clr_err ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
      end else if (clr_err) begin
        m_derr = 0;
        m_dcnt = 0;
      end
      if (issue) pend.push_back('{n_edge, issue_tag});
    end
    n_edge++;
  endtask

  task automatic model_check();
    chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_count", 32'(out_count), 32'(mq.size()));
    chk("m_data",  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    chk("m_credit", 32'(credit_ok), 32'((mq.size() + pend.size()) < DEPTH));
    chk("m_drop_err", 32'(drop_err), 32'(m_derr));
    chk("m_drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic set_in(input logic iss, input logic [3:0] tg, input logic [15:0] res,
                        input logic [5:0] f, input logic rdy, input logic clr);
    issue = iss; issue_tag = tg; alu_res = res; flg = f; out_ready = rdy; clr_err = clr;
  endtask

  task automatic idle(input logic rdy);
    set_in(1'b0, 4'h0, 16'h0, 6'h0, rdy, 1'b0);
  endtask

  task automatic fill_four();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 4'(i), 16'h0100 + 16'(i), 6'(i), 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    logic [3:0] exp_tags [4];
    tbl[0]  = '{1'b1, 4'h3, 16'h0000, 6'h00, 1'b0, 1'b0, 3'd0, 1'b1, 26'h0};
    tbl[1]  = '{1'b0, 4'h0, 16'h0000, 6'h00, 1'b0, 1'b0, 3'd0, 1'b1, 26'h0};
    tbl[2]  = '{1'b0, 4'h0, 16'h0012, 6'b001000, 1'b0, 1'b1, 3'd1, 1'b1, {4'h3, 16'h0012, 6'b001000}};
    tbl[3]  = '{1'b0, 4'h0, 16'h0000, 6'h00, 1'b1, 1'b0, 3'd0, 1'b1, 26'h0};
    tbl[4]  = '{1'b1, 4'h0, 16'h00A0, 6'h00, 1'b0, 1'b0, 3'd0, 1'b1, 26'h0};
    tbl[5]  = '{1'b1, 4'h1, 16'h00A0, 6'h00, 1'b0, 1'b0, 3'd0, 1'b1, 26'h0};
    tbl[6]  = '{1'b1, 4'h2, 16'h00A0, 6'h00, 1'b0, 1'b1, 3'd1, 1'b1, {4'h0, 16'h00A0, 6'h00}};
    tbl[7]  = '{1'b1, 4'h3, 16'h00A0, 6'h00, 1'b0, 1'b1, 3'd2, 1'b0, {4'h0, 16'h00A0, 6'h00}};
    tbl[8]  = '{1'b0, 4'h0, 16'h00A0, 6'h00, 1'b0, 1'b1, 3'd3, 1'b0, {4'h0, 16'h00A0, 6'h00}};
    tbl[9]  = '{1'b0, 4'h0, 16'h00A0, 6'h00, 1'b0, 1'b1, 3'd4, 1'b0, {4'h0, 16'h00A0, 6'h00}};
    tbl[10] = '{1'b0, 4'h0, 16'h00A0, 6'h00, 1'b1, 1'b1, 3'd3, 1'b1, {4'h1, 16'h00A0, 6'h00}};
    tbl[11] = '{1'b0, 4'h0, 16'h00A0, 6'h00, 1'b1, 1'b1, 3'd2, 1'b1, {4'h2, 16'h00A0, 6'h00}};
    tbl[12] = '{1'b0, 4'h0, 16'h00A0, 6'h00, 1'b1, 1'b1, 3'd1, 1'b1, {4'h3, 16'h00A0, 6'h00}};
    tbl[13] = '{1'b0, 4'h0, 16'h00A0, 6'h00, 1'b1, 1'b0, 3'd0, 1'b1, 26'h0};

    rst_n = 1'b0;
    idle(1'b0);
    model_reset();
    #3;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    chk("rst_credit", 32'(credit_ok), 32'h1);
    chk("rst_drop_err", 32'(drop_err), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    step();
    #3 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].iss, tbl[i].tag, tbl[i].res, tbl[i].f, tbl[i].rdy, 1'b0);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_vld));
      chk($sformatf("vec%0d_count", i), 32'(out_count), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_credit", i), 32'(credit_ok), 32'(tbl[i].exp_cr));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].exp_dat));
    end

    // Full FIFO with no pop: a late result is dropped, then drop-and-clear on one edge.
    fill_four();
    idle(1'b0); step(); step();
    set_in(1'b1, 4'h9, 16'h0999, 6'h3F, 1'b0, 1'b0); step();
    idle(1'b0); step(); step();
    chk("drop_err_set", 32'(drop_err), 32'h1);
    chk("drop_cnt_one", 32'(drop_cnt), 32'h1);
    chk("drop_count_full", 32'(out_count), 32'h4);
    chk("drop_head_tag", 32'(out_data[DW-1 -: 4]), 32'h0);
    set_in(1'b1, 4'h7, 16'h0777, 6'h00, 1'b0, 1'b0); step();
    idle(1'b0); step();
    set_in(1'b0, 4'h0, 16'h0, 6'h0, 1'b0, 1'b1); step();
    chk("clr_vs_drop_err", 32'(drop_err), 32'h1);
    chk("clr_vs_drop_cnt", 32'(drop_cnt), 32'h1);
    step();
    chk("clr_err", 32'(drop_err), 32'h0);
    chk("clr_cnt", 32'(drop_cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_a_tag%0d", i), 32'(out_data[DW-1 -: 4]), 32'(i));
      idle(1'b1); step();
    end
    chk("drain_a_empty", 32'(out_count), 32'h0);

    // Full FIFO with a pop on the capture edge: push is accepted, nothing dropped.
    fill_four();
    idle(1'b0); step(); step();
    set_in(1'b1, 4'h5, 16'h0555, 6'h15, 1'b0, 1'b0); step();
    idle(1'b0); step();
    idle(1'b1); step();
    chk("popfull_count", 32'(out_count), 32'h4);
    chk("popfull_drop", 32'(drop_err), 32'h0);
    chk("popfull_head", 32'(out_data[DW-1 -: 4]), 32'h1);
    exp_tags = '{4'h1, 4'h2, 4'h3, 4'h5};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_b_tag%0d", i), 32'(out_data[DW-1 -: 4]), 32'(exp_tags[i]));
      idle(1'b1); step();
    end
    chk("drain_b_empty", 32'(out_valid), 32'h0);

    // Reset while a command is in flight: nothing may be captured afterwards.
    set_in(1'b1, 4'hC, 16'h0CCC, 6'h01, 1'b0, 1'b0); step();
    idle(1'b0); step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_count", 32'(out_count), 32'h0);
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("arst_nocap%0d", i), 32'(out_count), 32'h0);
    end

    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom % 10) < 6, 4'($urandom), 16'($urandom), 6'($urandom),
             (c < 1500) ? (($urandom % 4) == 0) : (($urandom % 4) != 0),
             ($urandom % 1000) == 0);
      step();
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rand_arst_count", 32'(out_count), 32'h0);
        #1 rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
